// File: rtl/mru_list.sv
// mru_list: move-to-front list of DEPTH unique DATA_W-bit values with registered hit/evict reporting.
// Define MRU_STATS_EN to add saturating hit/miss counters (hit_cnt_out, miss_cnt_out).
module mru_list #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    flush_in,
    output logic [DEPTH*DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]        out_valid,
    output logic [CNT_W-1:0]        count_out,
    output logic                    hit_out,
    output logic [IDX_W-1:0]        hit_idx_out,
`ifdef MRU_STATS_EN
    output logic [15:0]             hit_cnt_out,
    output logic [15:0]             miss_cnt_out,
`endif
    output logic                    evict_valid_out,
    output logic [DATA_W-1:0]       evict_data_out
);

    logic [DATA_W-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [CNT_W-1:0]  count_r;
    logic [DEPTH-1:0]  match_s;
    logic [DEPTH-1:0]  shift_s;
    logic              hit_s;
    logic              full_s;
    logic [IDX_W-1:0]  hit_idx_s;

    // Match against valid slots only; entries are distinct so OR-ing indices yields the single hit slot.
    always_comb begin
        match_s   = '0;
        shift_s   = '0;
        hit_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = valid_r[i] && (data_r[i] == in_data);
            hit_idx_s  = hit_idx_s | (match_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        hit_s  = |match_s;
        full_s = (count_r == CNT_W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            shift_s[i] = !hit_s || (IDX_W'(i) <= hit_idx_s);
        end
    end

    // List state and reporting pulses; flush wins over a simultaneous insert.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
            valid_r         <= '0;
            count_r         <= '0;
            hit_out         <= 1'b0;
            hit_idx_out     <= '0;
            evict_valid_out <= 1'b0;
            evict_data_out  <= '0;
        end else if (flush_in) begin
            valid_r         <= '0;
            count_r         <= '0;
            hit_out         <= 1'b0;
            hit_idx_out     <= '0;
            evict_valid_out <= 1'b0;
        end else if (in_valid) begin
            data_r[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                if (shift_s[i]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
            hit_out         <= hit_s;
            hit_idx_out     <= hit_idx_s;
            evict_valid_out <= !hit_s && full_s;
            if (!hit_s) begin
                valid_r <= {valid_r[DEPTH-2:0], 1'b1};
                if (full_s) begin
                    evict_data_out <= data_r[DEPTH-1];
                end else begin
                    count_r <= count_r + CNT_W'(1);
                end
            end
        end else begin
            hit_out         <= 1'b0;
            hit_idx_out     <= '0;
            evict_valid_out <= 1'b0;
        end
    end

`ifdef MRU_STATS_EN
    // Saturating counters of accepted hits and misses.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            hit_cnt_out  <= 16'h0000;
            miss_cnt_out <= 16'h0000;
        end else if (flush_in) begin
            hit_cnt_out  <= 16'h0000;
            miss_cnt_out <= 16'h0000;
        end else if (in_valid) begin
            if (hit_s && (hit_cnt_out != 16'hFFFF)) begin
                hit_cnt_out <= hit_cnt_out + 16'h0001;
            end
            if (!hit_s && (miss_cnt_out != 16'hFFFF)) begin
                miss_cnt_out <= miss_cnt_out + 16'h0001;
            end
        end
    end
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_r[g];
    end
    assign out_valid = valid_r;
    assign count_out = count_r;

endmodule

// File: tb/tb_mru_list.sv
// tb_mru_list: directed + randomized check of mru_list against a queue-based move-to-front model.
module tb_mru_list;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                    clk_in = 1'b0;
    logic                    reset_n_in;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    flush_in;
    logic [DEPTH*DATA_W-1:0] out_data;
    logic [DEPTH-1:0]        out_valid;
    logic [CNT_W-1:0]        count_out;
    logic                    hit_out;
    logic [IDX_W-1:0]        hit_idx_out;
    logic                    evict_valid_out;
    logic [DATA_W-1:0]       evict_data_out;
`ifdef MRU_STATS_EN
    logic [15:0]             hit_cnt_out;
    logic [15:0]             miss_cnt_out;
`endif

    mru_list #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .in_valid(in_valid),
        .in_data(in_data),
        .flush_in(flush_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .count_out(count_out),
        .hit_out(hit_out),
        .hit_idx_out(hit_idx_out),
`ifdef MRU_STATS_EN
        .hit_cnt_out(hit_cnt_out),
        .miss_cnt_out(miss_cnt_out),
`endif
        .evict_valid_out(evict_valid_out),
        .evict_data_out(evict_data_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: front of the queue is slot 0.
    logic [DATA_W-1:0] q[$];
    bit                m_hit;
    int                m_idx;
    bit                m_ev;
    logic [DATA_W-1:0] m_evd;
    int                m_hits;
    int                m_misses;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit full_reset);
        q.delete();
        m_hit    = 1'b0;
        m_idx    = 0;
        m_ev     = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        if (full_reset) m_evd = '0;
    endtask

    task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit f);
        int k;
        m_hit = 1'b0;
        m_idx = 0;
        m_ev  = 1'b0;
        if (f) begin
            model_clear(1'b0);
        end else if (v) begin
            k = -1;
            foreach (q[i]) if (q[i] == d) k = i;
            if (k >= 0) begin
                q.delete(k);
                m_hit = 1'b1;
                m_idx = k;
                if (m_hits < 65535) m_hits++;
            end else begin
                if (q.size() == DEPTH) begin
                    m_ev  = 1'b1;
                    m_evd = q[DEPTH-1];
                    void'(q.pop_back());
                end
                if (m_misses < 65535) m_misses++;
            end
            q.push_front(d);
        end
    endtask

    task automatic compare_all();
        cmp("count_out", 64'(count_out), 64'(q.size()));
        cmp("out_valid", 64'(out_valid), 64'((1 << q.size()) - 1));
        foreach (q[i]) cmp($sformatf("slot%0d", i), 64'(out_data[i*DATA_W +: DATA_W]), 64'(q[i]));
        cmp("hit_out", 64'(hit_out), 64'(m_hit));
        cmp("hit_idx_out", 64'(hit_idx_out), 64'(m_idx));
        cmp("evict_valid_out", 64'(evict_valid_out), 64'(m_ev));
        cmp("evict_data_out", 64'(evict_data_out), 64'(m_evd));
`ifdef MRU_STATS_EN
        cmp("hit_cnt_out", 64'(hit_cnt_out), 64'(m_hits));
        cmp("miss_cnt_out", 64'(miss_cnt_out), 64'(m_misses));
`endif
    endtask

    // Mid-cycle check of every output against the model.
    always @(negedge clk_in) begin
        if (chk_en && reset_n_in) compare_all();
    end

    task automatic apply(input bit v, input logic [DATA_W-1:0] d, input bit f);
        @(negedge clk_in);
        in_valid = v;
        in_data  = d;
        flush_in = f;
        @(posedge clk_in);
        #1;
        model_step(v, d, f);
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_valid"}, 64'(out_valid), 64'h0);
        cmp({tag, "_count"}, 64'(count_out), 64'h0);
        cmp({tag, "_data"}, 64'(out_data), 64'h0);
        cmp({tag, "_hit"}, 64'(hit_out), 64'h0);
        cmp({tag, "_hidx"}, 64'(hit_idx_out), 64'h0);
        cmp({tag, "_ev"}, 64'(evict_valid_out), 64'h0);
        cmp({tag, "_evd"}, 64'(evict_data_out), 64'h0);
    endtask

    initial begin
        reset_n_in = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush_in   = 1'b0;
        model_clear(1'b1);
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_state("reset");
        @(negedge clk_in);
        reset_n_in = 1'b1;
        chk_en     = 1'b1;

        repeat (3) apply(1'b0, 8'h00, 1'b0);
        cmp("idle_valid", 64'(out_valid), 64'h0);
        cmp("idle_hit", 64'(hit_out), 64'h0);
        apply(1'b1, 8'h00, 1'b0);
        cmp("zero_miss_hit", 64'(hit_out), 64'h0);
        cmp("zero_count", 64'(count_out), 64'h1);
        cmp("zero_slot0", 64'(out_data[7:0]), 64'h00);

        apply(1'b0, 8'h00, 1'b1);
        apply(1'b1, 8'h11, 1'b0);
        apply(1'b1, 8'h22, 1'b0);
        apply(1'b1, 8'h33, 1'b0);
        apply(1'b1, 8'h44, 1'b0);
        cmp("fill_data", 64'(out_data), 64'h11223344);
        cmp("fill_count", 64'(count_out), 64'h4);
        cmp("fill_ev", 64'(evict_valid_out), 64'h0);
        apply(1'b1, 8'h55, 1'b0);
        cmp("evict_data", 64'(out_data), 64'h22334455);
        cmp("evict_pulse", 64'(evict_valid_out), 64'h1);
        cmp("evict_val", 64'(evict_data_out), 64'h11);
        cmp("evict_count", 64'(count_out), 64'h4);
        apply(1'b1, 8'h33, 1'b0);
        cmp("hit2_hit", 64'(hit_out), 64'h1);
        cmp("hit2_idx", 64'(hit_idx_out), 64'h2);
        cmp("hit2_data", 64'(out_data), 64'h22445533);
        cmp("hit2_ev", 64'(evict_valid_out), 64'h0);
        apply(1'b1, 8'h33, 1'b0);
        cmp("hit0_idx", 64'(hit_idx_out), 64'h0);
        cmp("hit0_data", 64'(out_data), 64'h22445533);
`ifdef MRU_STATS_EN
        cmp("stats_hits", 64'(hit_cnt_out), 64'd2);
        cmp("stats_misses", 64'(miss_cnt_out), 64'd5);
`endif
        apply(1'b1, 8'h77, 1'b1);
        cmp("flush_valid", 64'(out_valid), 64'h0);
        cmp("flush_count", 64'(count_out), 64'h0);
        cmp("flush_hit", 64'(hit_out), 64'h0);
        apply(1'b1, 8'h77, 1'b0);
        cmp("post_flush_hit", 64'(hit_out), 64'h0);
        cmp("post_flush_count", 64'(count_out), 64'h1);

        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 3) != 0, 8'($urandom_range(0, 9)), $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset pulse between clock edges.
        @(posedge clk_in);
        #2;
        reset_n_in = 1'b0;
        model_clear(1'b1);
        #1;
        check_reset_state("async_rst");
        #1;
        reset_n_in = 1'b1;

        for (int n = 0; n < 200; n++) begin
            apply($urandom_range(0, 3) != 0, 8'($urandom_range(0, 9)), $urandom_range(0, 29) == 0);
        end
        apply(1'b0, 8'h00, 1'b0);
        @(negedge clk_in);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
